// File: rtl/snake_pkg.sv
// Shared constants for the snake game IR front end: arrow-key codes,
// NEC nominal pulse widths, receiver FSM states and small helpers.
package snake_pkg;

  localparam logic [31:0] UP    = 32'h20DF6A95;
  localparam logic [31:0] DOWN  = 32'h20DFEA15;
  localparam logic [31:0] LEFT  = 32'h20DF1AE5;
  localparam logic [31:0] RIGHT = 32'h20DF9A65;

  localparam int unsigned NOM_LEAD_US  = 9000;
  localparam int unsigned NOM_SPACE_US = 4500;
  localparam int unsigned NOM_RPT_US   = 2250;
  localparam int unsigned NOM_BIT_US   = 562;
  localparam int unsigned NOM_ONE_US   = 1687;

  localparam int unsigned CNT_W = 20;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_LOW,
    LEAD_HIGH,
    BIT_LOW,
    BIT_HIGH,
    STOP
  } ir_state_t;

  // Cycle count for (nom_us * pct / 100) microseconds at clk_hz.
  function automatic logic [CNT_W-1:0] win_bound(input int unsigned nom_us,
                                                 input int unsigned clk_hz,
                                                 input int unsigned pct);
    logic [63:0] prod;
    prod = 64'(nom_us) * 64'(clk_hz) * 64'(pct) / 64'd100_000_000;
    return CNT_W'(prod);
  endfunction

  function automatic logic is_arrow(input logic [31:0] c);
    return (c == UP) || (c == DOWN) || (c == LEFT) || (c == RIGHT);
  endfunction

endpackage

// File: rtl/ir_nec_receiver_edge_sync.sv
// Two-flop synchronizer for the raw IR line plus rise/fall edge pulses.
// Flops reset to 1 so an idle (high) line produces no edge after reset.
module ir_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  // [0],[1] synchronizer stages; [2] previous synchronized level
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  // shift the line through the synchronizer and history flop
  always_comb begin
    sync_d = {sync_q[1:0], din};
  end

  // synchronizer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '1;
    else       sync_q <= sync_d;
  end

  assign rise = sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/ir_nec_receiver.sv
// NEC IR frame decoder: measures pulse widths between synchronized edges,
// shifts in 32 data bits MSB-first, validates the command complement and
// tracks the last accepted arrow key for the game logic.
module ir_nec_receiver
  import snake_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned TOL_PCT    = 25,
  parameter int unsigned TIMEOUT_US = 12000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ir_in,
  output logic [31:0] code,
  output logic        code_valid,
  output logic        repeat_seen,
  output logic        frame_err,
  output logic [31:0] direction
);

  localparam int unsigned LO_PCT = 100 - TOL_PCT;
  localparam int unsigned HI_PCT = 100 + TOL_PCT;

  localparam logic [CNT_W-1:0] LEAD_MIN  = win_bound(NOM_LEAD_US,  CLK_HZ, LO_PCT);
  localparam logic [CNT_W-1:0] LEAD_MAX  = win_bound(NOM_LEAD_US,  CLK_HZ, HI_PCT);
  localparam logic [CNT_W-1:0] SPACE_MIN = win_bound(NOM_SPACE_US, CLK_HZ, LO_PCT);
  localparam logic [CNT_W-1:0] SPACE_MAX = win_bound(NOM_SPACE_US, CLK_HZ, HI_PCT);
  localparam logic [CNT_W-1:0] RPT_MIN   = win_bound(NOM_RPT_US,   CLK_HZ, LO_PCT);
  localparam logic [CNT_W-1:0] RPT_MAX   = win_bound(NOM_RPT_US,   CLK_HZ, HI_PCT);
  localparam logic [CNT_W-1:0] BIT_MIN   = win_bound(NOM_BIT_US,   CLK_HZ, LO_PCT);
  localparam logic [CNT_W-1:0] BIT_MAX   = win_bound(NOM_BIT_US,   CLK_HZ, HI_PCT);
  localparam logic [CNT_W-1:0] ONE_MIN   = win_bound(NOM_ONE_US,   CLK_HZ, LO_PCT);
  localparam logic [CNT_W-1:0] ONE_MAX   = win_bound(NOM_ONE_US,   CLK_HZ, HI_PCT);
  localparam logic [CNT_W-1:0] TIMEOUT_CYC = win_bound(TIMEOUT_US, CLK_HZ, 100);

  function automatic logic in_win(input logic [CNT_W-1:0] w,
                                  input logic [CNT_W-1:0] lo,
                                  input logic [CNT_W-1:0] hi);
    return (w >= lo) && (w <= hi);
  endfunction

  logic ir_rise;
  logic ir_fall;

  ir_edge_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (ir_in),
    .rise  (ir_rise),
    .fall  (ir_fall)
  );

  ir_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [31:0]      shreg_q, shreg_d;
  logic             rpt_q, rpt_d;
  logic [31:0]      code_q, code_d;
  logic             code_valid_q, code_valid_d;
  logic             repeat_q, repeat_d;
  logic             err_q, err_d;
  logic [31:0]      dir_q, dir_d;

  // frame-level events handed from next-state logic to output logic
  logic ev_err;
  logic ev_frame;

  // width counter: restarts on every edge, saturates when the line is quiet
  always_comb begin
    cnt_d = cnt_q;
    if (ir_rise || ir_fall)  cnt_d = '0;
    else if (cnt_q != '1)    cnt_d = cnt_q + CNT_W'(1);
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      rpt_q        <= 1'b0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      repeat_q     <= 1'b0;
      err_q        <= 1'b0;
      dir_q        <= '0;
    end else begin
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      rpt_q        <= rpt_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      repeat_q     <= repeat_d;
      err_q        <= err_d;
      dir_q        <= dir_d;
    end
  end

  // next-state: classify each edge by the width that preceded it
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    rpt_d     = rpt_q;
    ev_err    = 1'b0;
    ev_frame  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ir_fall) begin
          state_d = LEAD_LOW;
          rpt_d   = 1'b0;
        end
      end
      LEAD_LOW: begin
        if (ir_rise) begin
          if (in_win(cnt_q, LEAD_MIN, LEAD_MAX)) state_d = LEAD_HIGH;
          else                                  ev_err  = 1'b1;
        end
      end
      LEAD_HIGH: begin
        if (ir_fall) begin
          if (in_win(cnt_q, SPACE_MIN, SPACE_MAX)) begin
            state_d   = BIT_LOW;
            bit_cnt_d = '0;
            shreg_d   = '0;
          end else if (in_win(cnt_q, RPT_MIN, RPT_MAX)) begin
            state_d = STOP;
            rpt_d   = 1'b1;
          end else begin
            ev_err = 1'b1;
          end
        end
      end
      BIT_LOW: begin
        if (ir_rise) begin
          if (in_win(cnt_q, BIT_MIN, BIT_MAX)) state_d = BIT_HIGH;
          else                                ev_err  = 1'b1;
        end
      end
      BIT_HIGH: begin
        if (ir_fall) begin
          if (in_win(cnt_q, BIT_MIN, BIT_MAX) || in_win(cnt_q, ONE_MIN, ONE_MAX)) begin
            shreg_d   = {shreg_q[30:0], in_win(cnt_q, ONE_MIN, ONE_MAX)};
            bit_cnt_d = bit_cnt_q + 5'd1;
            state_d   = (bit_cnt_q == 5'd31) ? STOP : BIT_LOW;
          end else begin
            ev_err = 1'b1;
          end
        end
      end
      STOP: begin
        if (ir_rise) begin
          if (in_win(cnt_q, BIT_MIN, BIT_MAX)) begin
            ev_frame = 1'b1;
            state_d  = IDLE;
          end else begin
            ev_err = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && !ev_frame && cnt_q >= TIMEOUT_CYC) ev_err = 1'b1;
    if (ev_err) state_d = IDLE;
  end

  // outputs: commit a checked frame, pulse status flags
  always_comb begin
    code_d       = code_q;
    dir_d        = dir_q;
    code_valid_d = 1'b0;
    repeat_d     = 1'b0;
    err_d        = ev_err;
    if (ev_frame) begin
      if (rpt_q) begin
        repeat_d = 1'b1;
      end else if (shreg_q[15:8] == ~shreg_q[7:0]) begin
        code_d       = shreg_q;
        code_valid_d = 1'b1;
        if (is_arrow(shreg_q)) dir_d = shreg_q;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  assign code        = code_q;
  assign code_valid  = code_valid_q;
  assign repeat_seen = repeat_q;
  assign frame_err   = err_q;
  assign direction   = dir_q;

endmodule

// File: tb/tb_ir_nec_receiver.sv
// Directed bench for ir_nec_receiver. Clocked at 100 kHz (1 cycle = 10 us)
// so full NEC frames stay a few thousand cycles long.
module tb_ir_nec_receiver;
  import snake_pkg::*;

  localparam int unsigned TB_CLK_HZ  = 100_000;
  localparam int unsigned US_PER_CYC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ir_in = 1'b1;
  logic [31:0] code;
  logic        code_valid;
  logic        repeat_seen;
  logic        frame_err;
  logic [31:0] direction;

  int checks = 0;
  int failures = 0;
  int n_valid = 0;
  int n_rpt = 0;
  int n_err = 0;
  int v0, r0, e0, found;

  always #5 clk = ~clk;

  ir_nec_receiver #(
    .CLK_HZ     (TB_CLK_HZ),
    .TOL_PCT    (25),
    .TIMEOUT_US (12000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ir_in       (ir_in),
    .code        (code),
    .code_valid  (code_valid),
    .repeat_seen (repeat_seen),
    .frame_err   (frame_err),
    .direction   (direction)
  );

  // pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (code_valid)  n_valid++;
      if (repeat_seen) n_rpt++;
      if (frame_err)   n_err++;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic lvl, input int unsigned us);
    ir_in = lvl;
    repeat ((us + US_PER_CYC / 2) / US_PER_CYC) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic leader(input int unsigned space_us);
    drive(1'b0, 9000);
    drive(1'b1, space_us);
  endtask

  task automatic send_bits(input logic [31:0] data, input int from_k, input int to_k,
                           input int stretch_k);
    for (int k = from_k; k <= to_k; k++) begin
      drive(1'b0, 562);
      if (k == stretch_k) drive(1'b1, 2500);
      else                drive(1'b1, data[31-k] ? 1687 : 562);
    end
  endtask

  task automatic stop_burst();
    drive(1'b0, 562);
    ir_in = 1'b1;
  endtask

  task automatic send_frame(input logic [31:0] data);
    leader(4500);
    send_bits(data, 0, 31, -1);
    stop_burst();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // reset state
    reset = 1'b1;
    ir_in = 1'b1;
    idle(5);
    check("rst_code", code, 32'h0);
    check("rst_valid", 32'(code_valid), 32'h0);
    check("rst_repeat", 32'(repeat_seen), 32'h0);
    check("rst_err", 32'(frame_err), 32'h0);
    check("rst_dir", direction, 32'h0);
    reset = 1'b0;
    idle(5);

    // 1: UP frame, code_valid exactly 3 cycles after stop rise
    v0 = n_valid; e0 = n_err;
    send_frame(UP);
    idle(2);
    check("t1_valid_c2", 32'(code_valid), 32'h0);
    idle(1);
    check("t1_valid_c3", 32'(code_valid), 32'h1);
    check("t1_code", code, 32'h20DF6A95);
    check("t1_dir", direction, 32'h20DF6A95);
    idle(1);
    check("t1_valid_c4", 32'(code_valid), 32'h0);
    idle(20);
    check("t1_valid_cnt", 32'(n_valid - v0), 32'd1);
    check("t1_err_cnt", 32'(n_err - e0), 32'd0);

    // 2: non-arrow key updates code only
    v0 = n_valid;
    send_frame(32'h20DF10EF);
    idle(10);
    check("t2_code", code, 32'h20DF10EF);
    check("t2_dir", direction, 32'h20DF6A95);
    check("t2_valid_cnt", 32'(n_valid - v0), 32'd1);

    // 3: repeat frame
    v0 = n_valid; r0 = n_rpt; e0 = n_err;
    leader(2250);
    stop_burst();
    idle(10);
    check("t3_rpt_cnt", 32'(n_rpt - r0), 32'd1);
    check("t3_valid_cnt", 32'(n_valid - v0), 32'd0);
    check("t3_err_cnt", 32'(n_err - e0), 32'd0);
    check("t3_code", code, 32'h20DF10EF);
    check("t3_dir", direction, 32'h20DF6A95);

    // 4: space of bit 10 stretched to 2500 us, then a good RIGHT frame
    v0 = n_valid; e0 = n_err;
    leader(4500);
    send_bits(UP, 0, 10, 10);
    stop_burst();
    idle(10);
    check("t4_err_cnt", 32'(n_err - e0), 32'd1);
    check("t4_valid_cnt", 32'(n_valid - v0), 32'd0);
    check("t4_code", code, 32'h20DF10EF);
    check("t4_fsm_idle", 32'(dut.state_q), 32'(IDLE));
    v0 = n_valid;
    send_frame(RIGHT);
    idle(10);
    check("t4_right_code", code, 32'h20DF9A65);
    check("t4_right_dir", direction, 32'h20DF9A65);
    check("t4_right_valid", 32'(n_valid - v0), 32'd1);

    // 5a: broken command complement
    v0 = n_valid; e0 = n_err;
    send_frame(32'h20DF6A94);
    idle(10);
    check("t5_cmp_err", 32'(n_err - e0), 32'd1);
    check("t5_cmp_valid", 32'(n_valid - v0), 32'd0);
    check("t5_cmp_code", code, 32'h20DF9A65);

    // 5b: line held high 13000 us mid-frame; timeout is 1200 cycles after the
    // counter restarts, which itself lags ir_in by 3 cycles, plus 1 register
    e0 = n_err;
    leader(4500);
    send_bits(UP, 0, 3, -1);
    drive(1'b0, 562);
    ir_in = 1'b1;
    found = 0;
    for (int i = 1; i <= 1300; i++) begin
      @(posedge clk);
      #1;
      if (frame_err && found == 0) found = i;
    end
    check("t5_timeout_cyc", 32'(found), 32'd1204);
    check("t5_timeout_cnt", 32'(n_err - e0), 32'd1);
    check("t5_timeout_dir", direction, 32'h20DF9A65);

    // 6: reset at bit 20 of a DOWN frame
    leader(4500);
    send_bits(DOWN, 0, 19, -1);
    reset = 1'b1;
    #1;
    check("t6_rst_code", code, 32'h0);
    check("t6_rst_dir", direction, 32'h0);
    check("t6_rst_valid", 32'(code_valid), 32'h0);
    check("t6_rst_err", 32'(frame_err), 32'h0);
    idle(3);
    reset = 1'b0;
    v0 = n_valid;
    send_bits(DOWN, 20, 31, -1);
    stop_burst();
    idle(20);
    check("t6_tail_valid", 32'(n_valid - v0), 32'd0);
    check("t6_tail_code", code, 32'h0);
    v0 = n_valid;
    send_frame(DOWN);
    idle(10);
    check("t6_down_dir", direction, 32'h20DFEA15);
    check("t6_down_code", code, 32'h20DFEA15);
    check("t6_down_valid", 32'(n_valid - v0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
